regfile_access_ctrl: RTL and testbench
======================================

# regfile_access_ctrl

Controller that owns every access to the eBPF core's 10-entry × 64-bit GPR file (r0–r9).
- Shares the file's single dst/src read and single write port between the execution core and a host/debug port.
- Runs a sequential zeroing pass after reset or on request.
- Sits between the core datapath and `register_file`; it is the only driver of the file's index, write-data and write-enable inputs.

## Interface
Parameters:
- NUM_REGS, 10, number of valid GPRs; indices ≥ NUM_REGS are invalid.
- DATA_W, 64, register width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- core_active  in  1  core owns the file this cycle.
- core_dst  in  4  core dst index.
- core_src  in  4  core src index.
- core_wdata  in  DATA_W  core write data.
- core_we  in  1  core write enable.
- core_dstRead  out  DATA_W  dst read data to core.
- core_srcRead  out  DATA_W  src read data to core.
- core_exc  out  2  register exception to core.
- core_stall  out  1  core must hold; the file is being cleared.
- host_req_valid  in  1  host request valid.
- host_req_ready  out  1  host request accepted when valid && ready.
- host_req_write  in  1  1 = write, 0 = read.
- host_req_idx  in  4  target register.
- host_req_wdata  in  DATA_W  host write data.
- host_rsp_valid  out  1  one-cycle response strobe; no backpressure.
- host_rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- host_rsp_err  out  1  index invalid.
- clear_start  in  1  request a zeroing pass.
- clear_busy  out  1  zeroing pass in progress.
- rf_dst, rf_src  out  4  to register file.
- rf_dstWrite  out  DATA_W  to register file.
- rf_writeEnable  out  1  to register file.
- rf_dstRead, rf_srcRead  in  DATA_W  from register file.
- rf_exc  in  2  from register file.

## Operation
- **FSM states:** CLEAR, IDLE.
- **Reset:**
  - Forces CLEAR with clear_cnt = 0.
  - Outputs during reset: clear_busy=1, core_stall=1, host_req_ready=0, host_rsp_valid=0, host_rsp_err=0, host_rsp_rdata=0.
- **CLEAR:**
  - Drives rf_dst=clear_cnt, rf_dstWrite=0, rf_writeEnable=1, rf_src=0; clear_cnt increments each cycle.
  - When clear_cnt = NUM_REGS−1, the next state is IDLE.
  - core_stall=1, host_req_ready=0, core_exc=NO_EXCEPTION.
  - clear_start is ignored in this state.
- **IDLE with core_active=1:**
  - The core path passes straight through: rf_dst/rf_src/rf_dstWrite/rf_writeEnable ← core_*; core_dstRead/core_srcRead/core_exc ← rf_*.
  - host_req_ready=0.
- **IDLE with core_active=0:**
  - host_req_ready=1 and rf_dst=rf_src=host_req_idx.
  - rf_writeEnable = host_req_valid && host_req_write && idx<NUM_REGS.
  - core_exc=NO_EXCEPTION; core read outputs are 0.
- **Host response:** registered on the accept edge.
  - rsp_valid=1 for exactly one cycle.
  - rsp_err = idx≥NUM_REGS (the INVALID_DST condition).
  - rsp_rdata = rf_dstRead for a valid read, else 0.
  - An invalid write never asserts rf_writeEnable.
- **clear_start in IDLE:** CLEAR is entered next cycle. A host request accepted in the same cycle still completes normally.

## Timing
- Clear pass: 10 cycles. The first zero write lands on the first edge after reset deasserts; clear_busy falls in the cycle after r9 is written.
- Host read latency: 1. Accept at edge T; rsp_valid and rdata are valid in cycle T+1 and reflect the register value before any write at edge T.
- Host write: the register updates at accept edge T; the response appears in cycle T+1.
- Back-to-back host requests are accepted every cycle. A read immediately following a write to the same index returns the new value.
- core_active rising while host_req_valid=1: ready drops combinationally and the core wins; the host request stays pending.
- Reset during CLEAR restarts from r0. Reset in the cycle after an accept suppresses that response.
- Core path has zero added latency; there are no registers on it.

## Structure
- Shared package `regfile_ctrl_pkg`:
  - state enum {CLEAR, IDLE};
  - NUM_REGS constant;
  - exception encodings reused from `register_exception` (NO_EXCEPTION, INVALID_DST, INVALID_SRC).
- Single module; no sub-modules. The port mux is combinational, and the FSM, clear counter and response registers are in one `always_ff`.

## Test plan
- Reset, then release -> clear_busy high for 10 cycles; rf_writeEnable=1 with rf_dst stepping 0..9 and data 0; afterwards host reads of r0..r9 return 0.
- core_active=0, host write r3=0xDEADBEEF_CAFEF00D, then read r3 on the next cycle -> the read response returns 0xDEADBEEF_CAFEF00D with err=0, one cycle after accept.
- Host read of idx 12 -> rsp_err=1, rdata=0, no file write; host write of idx 10 -> err=1, rf_writeEnable never asserted.
- Host request pending when core_active rises -> ready=0 while the core writes r5=7; after core_active falls, the host request is accepted and reads r5=7.
- clear_start after r1..r9 are written with nonzero values -> 10-cycle clear with core_stall=1; all registers read back 0.
- Reset asserted at clear_cnt=4 -> the pass restarts at r0 and takes a full 10 cycles.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared types and constants for the GPR file access controller
package regfile_ctrl_pkg;
   localparam int NUM_REGS = 10;
   typedef enum logic {CLEAR, IDLE} state_t;
   typedef enum logic [1:0] {
      NO_EXCEPTION = 2'd0,
      INVALID_DST  = 2'd1,
      INVALID_SRC  = 2'd2
   } reg_exc_t;
endpackage

// File: rtl/regfile_access_ctrl_if.sv
// regfile_access_ctrl_if: host/debug request-response port of the GPR file controller
interface regfile_access_ctrl_if #(parameter int DATA_W = 64);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [3:0]        req_idx;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   modport master (output req_valid, req_write, req_idx, req_wdata,
                   input  req_ready, rsp_valid, rsp_rdata, rsp_err);
   modport slave  (input  req_valid, req_write, req_idx, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: shares the GPR file ports between core and host, with a sequential zeroing pass
module regfile_access_ctrl #(
   parameter int NUM_REGS = regfile_ctrl_pkg::NUM_REGS,
   parameter int DATA_W   = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 core_active,
   input  logic [3:0]           core_dst,
   input  logic [3:0]           core_src,
   input  logic [DATA_W-1:0]    core_wdata,
   input  logic                 core_we,
   output logic [DATA_W-1:0]    core_dstRead,
   output logic [DATA_W-1:0]    core_srcRead,
   output logic [1:0]           core_exc,
   output logic                 core_stall,
   regfile_access_ctrl_if.slave host,
   input  logic                 clear_start,
   output logic                 clear_busy,
   output logic [3:0]           rf_dst,
   output logic [3:0]           rf_src,
   output logic [DATA_W-1:0]    rf_dstWrite,
   output logic                 rf_writeEnable,
   input  logic [DATA_W-1:0]    rf_dstRead,
   input  logic [DATA_W-1:0]    rf_srcRead,
   input  logic [1:0]           rf_exc
);
   import regfile_ctrl_pkg::*;

   localparam logic [3:0] LAST = 4'(NUM_REGS - 1);

   state_t            state, state_nx;
   logic [3:0]        clear_cnt;
   logic              rsp_valid_q, rsp_err_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              idx_ok, accept;

   assign idx_ok = host.req_idx <= LAST;
   assign accept = host.req_valid && host.req_ready;

   // Reset gates every write so the first zero write lands only after release
   always_comb begin
      state_nx       = state;
      rf_dst         = '0;
      rf_src         = '0;
      rf_dstWrite    = '0;
      rf_writeEnable = 1'b0;
      core_dstRead   = '0;
      core_srcRead   = '0;
      core_exc       = NO_EXCEPTION;
      host.req_ready = 1'b0;
      if (state == CLEAR) begin
         rf_dst         = clear_cnt;
         rf_writeEnable = !reset;
         state_nx       = (clear_cnt == LAST) ? IDLE : CLEAR;
      end else if (core_active) begin
         rf_dst         = core_dst;
         rf_src         = core_src;
         rf_dstWrite    = core_wdata;
         rf_writeEnable = core_we && !reset;
         core_dstRead   = rf_dstRead;
         core_srcRead   = rf_srcRead;
         core_exc       = rf_exc;
         state_nx       = clear_start ? CLEAR : IDLE;
      end else begin
         host.req_ready = !reset;
         rf_dst         = host.req_idx;
         rf_src         = host.req_idx;
         rf_dstWrite    = host.req_wdata;
         rf_writeEnable = host.req_valid && host.req_write && idx_ok && !reset;
         state_nx       = clear_start ? CLEAR : IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= CLEAR;
         clear_cnt   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state       <= state_nx;
         clear_cnt   <= (state == CLEAR && clear_cnt != LAST) ? clear_cnt + 4'd1 : '0;
         rsp_valid_q <= accept;
         rsp_err_q   <= accept && !idx_ok;
         rsp_rdata_q <= (accept && !host.req_write && idx_ok) ? rf_dstRead : '0;
      end
   end

   assign clear_busy     = reset || state == CLEAR;
   assign core_stall     = clear_busy;
   assign host.rsp_valid = rsp_valid_q && !reset;
   assign host.rsp_err   = rsp_err_q && !reset;
   assign host.rsp_rdata = reset ? '0 : rsp_rdata_q;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: scoreboard bench with a behavioural register file behind the controller
module tb_regfile_access_ctrl;
   import regfile_ctrl_pkg::*;
   localparam int DW = 64;

   logic clk = 0, reset = 1;
   always #5 clk = ~clk;

   logic          core_active = 0, core_we = 0, clear_start = 0;
   logic [3:0]    core_dst = 0, core_src = 0;
   logic [DW-1:0] core_wdata = 0, core_dstRead, core_srcRead;
   logic [1:0]    core_exc, rf_exc;
   logic          core_stall, clear_busy, rf_writeEnable;
   logic [3:0]    rf_dst, rf_src;
   logic [DW-1:0] rf_dstWrite, rf_dstRead, rf_srcRead;

   regfile_access_ctrl_if #(.DATA_W(DW)) host ();

   regfile_access_ctrl #(.NUM_REGS(10), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .core_active(core_active), .core_dst(core_dst),
      .core_src(core_src), .core_wdata(core_wdata), .core_we(core_we),
      .core_dstRead(core_dstRead), .core_srcRead(core_srcRead), .core_exc(core_exc),
      .core_stall(core_stall), .host(host.slave), .clear_start(clear_start),
      .clear_busy(clear_busy), .rf_dst(rf_dst), .rf_src(rf_src), .rf_dstWrite(rf_dstWrite),
      .rf_writeEnable(rf_writeEnable), .rf_dstRead(rf_dstRead), .rf_srcRead(rf_srcRead),
      .rf_exc(rf_exc)
   );

   // Behavioural register file; preload fills it with garbage so clearing is observable
   logic [DW-1:0] regs [10];
   logic          preload = 0, bad_we = 0;
   always @(posedge clk) begin
      if (preload) for (int i = 0; i < 10; i++) regs[i] <= 64'hA5A5_0000_0000_0000 | 64'(i + 1);
      else if (rf_writeEnable) begin
         if (rf_dst < 10) regs[rf_dst] <= rf_dstWrite;
         else bad_we <= 1'b1;
      end
   end
   assign rf_dstRead = rf_dst < 10 ? regs[rf_dst] : '0;
   assign rf_srcRead = rf_src < 10 ? regs[rf_src] : '0;
   assign rf_exc = rf_dst >= 10 ? 2'(INVALID_DST) : rf_src >= 10 ? 2'(INVALID_SRC) : 2'(NO_EXCEPTION);

   typedef struct {logic err; logic [DW-1:0] rdata; int cyc;} exp_t;
   exp_t          q[$];
   logic [DW-1:0] model [10];
   int            cyc = 0, checks = 0, errors = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (host.rsp_valid === 1'b1) begin
         exp_t e;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected got err=%b rdata=%h expected no response", host.rsp_err, host.rsp_rdata);
         end else begin
            e = q.pop_front();
            if (host.rsp_err !== e.err || host.rsp_rdata !== e.rdata || cyc != e.cyc) begin
               errors++;
               $display("FAIL host_rsp got err=%b rdata=%h cyc=%0d expected err=%b rdata=%h cyc=%0d",
                        host.rsp_err, host.rsp_rdata, cyc, e.err, e.rdata, e.cyc);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1);
   end

   task automatic host_op(input logic wr, input logic [3:0] idx, input logic [DW-1:0] wd);
      int n = 0;
      host.req_valid = 1; host.req_write = wr; host.req_idx = idx; host.req_wdata = wd;
      #1;
      while (host.req_ready !== 1'b1 && n < 50) begin @(posedge clk); #2; n++; end
      checks++;
      if (host.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL host_accept idx=%0d got ready=%b expected 1", idx, host.req_ready);
      end else begin
         q.push_back('{err: idx >= 10, rdata: (!wr && idx < 10) ? model[idx] : 64'd0, cyc: cyc + 1});
         if (wr && idx < 10) model[idx] = wd;
      end
      @(posedge clk); #1;
      host.req_valid = 0;
   endtask

   task automatic read_all();
      for (int i = 0; i < 10; i++) host_op(1'b0, 4'(i), '0);
   endtask

   task automatic zero_model();
      for (int i = 0; i < 10; i++) model[i] = '0;
   endtask

   task automatic count_clear(input string name);
      int n = 0;
      while (core_stall === 1'b1 && n < 50) begin n++; @(posedge clk); #1; end
      checks++;
      if (n != 10) begin errors++; $display("FAIL %s_cycles got %0d expected 10", name, n); end
      zero_model();
   endtask

   task automatic test_reset();
      host.req_valid = 0; host.req_write = 0; host.req_idx = 0; host.req_wdata = 0;
      preload = 1; reset = 1;
      @(posedge clk); #1 preload = 0;
      @(posedge clk); #1;
      checks++;
      if ({clear_busy, core_stall, host.req_ready, host.rsp_valid, host.rsp_err, rf_writeEnable} !== 6'b110000
          || host.rsp_rdata !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b stall=%b ready=%b rv=%b err=%b we=%b rd=%h expected 110000 rd=0",
                  clear_busy, core_stall, host.req_ready, host.rsp_valid, host.rsp_err, rf_writeEnable, host.rsp_rdata);
      end
      reset = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if (rf_writeEnable !== 1'b1 || rf_dst !== 4'(k) || rf_dstWrite !== '0 || clear_busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_step%0d got we=%b dst=%0d wd=%h busy=%b expected we=1 dst=%0d wd=0 busy=1",
                     k, rf_writeEnable, rf_dst, rf_dstWrite, clear_busy, k);
         end
      end
      @(negedge clk);
      checks++;
      if (clear_busy !== 1'b0) begin errors++; $display("FAIL clear_done got busy=%b expected 0", clear_busy); end
      @(posedge clk); #1;
      zero_model();
      read_all();
   endtask

   task automatic test_host_rw();
      host_op(1'b1, 4'd3, 64'hDEADBEEF_CAFEF00D);
      host_op(1'b0, 4'd3, '0);
      host_op(1'b1, 4'd0, 64'h0123_4567_89AB_CDEF);
      host_op(1'b1, 4'd9, 64'hFFFF_0000_FFFF_0000);
      host_op(1'b0, 4'd0, '0);
      host_op(1'b0, 4'd9, '0);
   endtask

   task automatic test_invalid();
      host_op(1'b0, 4'd12, '0);
      host_op(1'b1, 4'd10, 64'h1234);
      host_op(1'b1, 4'd15, 64'h5678);
      @(posedge clk); #1;
      checks++;
      if (bad_we !== 1'b0) begin errors++; $display("FAIL invalid_write got bad_we=%b expected 0", bad_we); end
      read_all();
   endtask

   task automatic test_core_preempt();
      host.req_valid = 1; host.req_write = 0; host.req_idx = 5;
      core_active = 1; core_dst = 5; core_src = 3; core_we = 1; core_wdata = 64'd7;
      #1;
      checks++;
      if (host.req_ready !== 1'b0 || core_srcRead !== model[3] || core_exc !== 2'(NO_EXCEPTION)
          || rf_writeEnable !== 1'b1 || rf_dst !== 4'd5) begin
         errors++;
         $display("FAIL core_write got ready=%b src=%h exc=%0d we=%b dst=%0d expected 0 %h 0 1 5",
                  host.req_ready, core_srcRead, core_exc, rf_writeEnable, rf_dst, model[3]);
      end
      @(posedge clk); #1;
      model[5] = 64'd7;
      core_we = 0; core_dst = 2; core_src = 11;
      #1;
      checks++;
      if (host.req_ready !== 1'b0 || core_exc !== 2'(INVALID_SRC) || core_dstRead !== model[2]) begin
         errors++;
         $display("FAIL core_read got ready=%b exc=%0d dst=%h expected 0 %0d %h",
                  host.req_ready, core_exc, core_dstRead, INVALID_SRC, model[2]);
      end
      core_active = 0; core_src = 0;
      #1;
      checks++;
      if (host.req_ready !== 1'b1 || core_dstRead !== '0 || core_exc !== 2'(NO_EXCEPTION)) begin
         errors++;
         $display("FAIL host_mode got ready=%b dst=%h exc=%0d expected 1 0 0", host.req_ready, core_dstRead, core_exc);
      end
      host_op(1'b0, 4'd5, '0);
   endtask

   task automatic test_clear_start();
      for (int i = 1; i < 10; i++) host_op(1'b1, 4'(i), 64'h1111_0000_0000_0001 * 64'(i));
      clear_start = 1;
      @(posedge clk); #1 clear_start = 0;
      count_clear("clear_start");
      read_all();
   endtask

   task automatic test_reset_restart();
      host_op(1'b1, 4'd2, 64'h22);
      host_op(1'b1, 4'd8, 64'h88);
      clear_start = 1;
      @(posedge clk); #1 clear_start = 0;
      repeat (4) begin @(posedge clk); #1; end
      checks++;
      if (rf_dst !== 4'd4 || clear_busy !== 1'b1) begin
         errors++;
         $display("FAIL clear_mid got dst=%0d busy=%b expected 4 1", rf_dst, clear_busy);
      end
      reset = 1;
      @(posedge clk); #1 reset = 0;
      #1;
      checks++;
      if (rf_dst !== 4'd0 || rf_writeEnable !== 1'b1) begin
         errors++;
         $display("FAIL restart got dst=%0d we=%b expected 0 1", rf_dst, rf_writeEnable);
      end
      count_clear("restart");
      read_all();
   endtask

   task automatic test_rsp_suppress();
      host.req_valid = 1; host.req_write = 0; host.req_idx = 3;
      #1;
      checks++;
      if (host.req_ready !== 1'b1) begin errors++; $display("FAIL suppress_ready got %b expected 1", host.req_ready); end
      @(posedge clk); #1;
      host.req_valid = 0; reset = 1;
      #1;
      checks++;
      if (host.rsp_valid !== 1'b0) begin errors++; $display("FAIL suppress_rsp got %b expected 0", host.rsp_valid); end
      @(posedge clk); #1 reset = 0;
      count_clear("suppress");
   endtask

   initial begin
      test_reset();
      test_host_rw();
      test_invalid();
      test_core_preempt();
      test_clear_start();
      test_reset_restart();
      test_rsp_suppress();
      repeat (3) @(posedge clk);
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d pending expected 0", q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
